window_3x3_former: RTL
======================

// Module: window_3x3_former
// PURPOSE
//  Reader side of the preparation-stage line buffers. Consumes three vertically aligned
//  pixel taps per beat: the live pixel plus two line-delayed copies from chained line buffers.
//  Assembles a sliding 3x3 window and flags which windows are fully valid.
//  Feeds the filter core (median/sort) with one window per accepted beat.
// PARAMETERS
//  DATA_W      8    pixel width in bits
//  IMG_WIDTH   17   pixels per image row (matches line buffer DEPTH)
//  IMG_HEIGHT  17   rows per frame
// PORTS
//  clk           in   1         single clock, all logic on rising edge
//  rst           in   1         synchronous, active-high reset
//  done_i        in   1         input beat valid; taps sampled only when high
//  row0_i        in   DATA_W    pixel two lines ago (output of second line buffer)
//  row1_i        in   DATA_W    pixel one line ago (output of first line buffer)
//  row2_i        in   DATA_W    current pixel (live stream)
//  window_o      out  9*DATA_W  window; pixel (r,c) at [DATA_W*(3*r+c) +: DATA_W]
//  done_o        out  1         window_o holds a fully valid 3x3 window this cycle
//  frame_done_o  out  1         one-cycle pulse: last pixel of frame accepted
// BEHAVIOUR
//  - Reset (synchronous, active-high):
//    - window registers, col_cnt and row_cnt clear to 0.
//    - done_o and frame_done_o clear to 0.
//  - Window: 3 rows x 3 columns of registers. r=0 is row0_i (oldest line), r=2 is row2_i.
//    c=2 is the newest column and c=0 the oldest.
//  - Accepted beat (done_i=1):
//    - Each row shifts one column: c0<=c1, c1<=c2, c2<=row{r}_i.
//    - col_cnt advances; row_cnt advances when col_cnt wraps from IMG_WIDTH-1.
//  - done_i=0: window, counters and frame state hold. done_o=0 and frame_done_o=0 next cycle.
//  - done_o is registered on the same edge as the shift, so latency is 1 cycle from the
//    accepted beat. done_o=1 iff the beat had col_cnt>=2 and row_cnt>=2 (pre-increment values).
//    Edge windows are therefore suppressed.
//  - Valid windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//  - Column wrap:
//    - After col_cnt=IMG_WIDTH-1, col_cnt returns to 0.
//    - The window is NOT flushed. The first two beats of a new row carry stale columns,
//      which are masked by the col_cnt>=2 rule.
//  - Frame wrap:
//    - Beat at (row_cnt=IMG_HEIGHT-1, col_cnt=IMG_WIDTH-1) sets frame_done_o=1 for 1 cycle.
//    - Both counters return to 0 and the next beat starts a new frame.
//  - Counters: width $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT), unsigned, never exceed max.
//  - No arithmetic on pixel data; values pass through unmodified.
//  - Reset mid-frame: counters and window return to 0 on that edge. The next accepted beat
//    is treated as (row 0, col 0).
//  - Back-to-back frames with done_i held high: no bubble required.
//  - Controller FSM: 2 states, with transitions on accepted beats only.
//    - FILL: row_cnt<2.
//    - STREAM: row_cnt>=2; done_o may assert.
//    - STREAM->FILL on frame wrap; FILL->STREAM when row_cnt reaches 2.
// STRUCTURE
//  - Shared package: DATA_W default, window index function idx(r,c)=3*r+c, WIN_W=9*DATA_W.
//  - Controller/datapath split:
//    - window_3x3_controller: col/row counters, FILL/STREAM FSM, done_o, frame_done_o.
//    - Datapath: 9 shift registers, inline in the top.
// TESTING (bench uses IMG_WIDTH=5, IMG_HEIGHT=4, pixel(r,c)=10*r+c fed via taps)
//  1 Reset then 20 continuous beats:
//    - done_o pulses 6 times: rows 2-3, cols 2-4.
//    - First valid window: row0=(0,1,2), row1=(10,11,12), row2=(20,21,22).
//  2 Frame end:
//    - Beat (3,4) -> frame_done_o=1 for exactly 1 cycle.
//    - Next beat is col 0 row 0 with done_o=0.
//  3 done_i gaps:
//    - Alternate done_i 1/0 over a frame -> same 6 windows/values as test 1.
//    - done_o never high on an idle cycle.
//  4 Column wrap:
//    - Beats (2,0),(2,1) -> done_o=0.
//    - Beat (2,2) -> done_o=1 and window has no row-1 leftover columns.
//  5 Reset mid-frame:
//    - Assert rst after beat (2,3) -> done_o=0 and window_o=0 next cycle.
//    - Restart: no done_o until 3rd row col 2.
//  6 Back-to-back frames:
//    - 2 frames, done_i always high -> 12 done_o pulses and 2 frame_done_o pulses.

Source files
------------

// File: rtl/window_3x3_former_pkg.sv
// Shared types and constants for the 3x3 window former.
// Also holds the helper that maps window coordinates to a bit-slice index.
package window_3x3_former_pkg;

  localparam int DATA_W_DFLT     = 8;
  localparam int IMG_WIDTH_DFLT  = 17;
  localparam int IMG_HEIGHT_DFLT = 17;
  localparam int WIN_W           = 9 * DATA_W_DFLT;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } ctrl_state_e;

  // Pixel (r,c) occupies slice [DATA_W*idx(r,c) +: DATA_W] of the flattened window.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/window_3x3_former_if.sv
// Tap/window bundle between the line buffers, the window former and the filter core.
// The slave modport is the window former's view of the bundle.
interface window_3x3_former_if
  import window_3x3_former_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
);

  logic                  done_i;
  logic [DATA_W-1:0]     row0_i;
  logic [DATA_W-1:0]     row1_i;
  logic [DATA_W-1:0]     row2_i;
  logic [9*DATA_W-1:0]   window_o;
  logic                  done_o;
  logic                  frame_done_o;

  modport master (
    output done_i, row0_i, row1_i, row2_i,
    input  window_o, done_o, frame_done_o
  );

  modport slave (
    input  done_i, row0_i, row1_i, row2_i,
    output window_o, done_o, frame_done_o
  );

endinterface

// File: rtl/window_3x3_former_controller.sv
// Column/row position tracking and the FILL/STREAM controller for the window former.
// Flags fully valid windows and the last beat of each frame, one cycle after the beat.
module window_3x3_controller
  import window_3x3_former_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DFLT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic done_i,
  output logic done_o,
  output logic frame_done_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  ctrl_state_e      state, state_nxt;
  logic [COL_W-1:0] col_cnt, col_nxt;
  logic [ROW_W-1:0] row_cnt, row_nxt;
  logic             done_nxt, frame_done_nxt;
  logic             col_last, row_last;

  assign col_last = (col_cnt == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_cnt == ROW_W'(IMG_HEIGHT - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    col_nxt        = col_cnt;
    row_nxt        = row_cnt;
    done_nxt       = 1'b0;
    frame_done_nxt = 1'b0;
    if (done_i) begin
      // STREAM already implies row_cnt>=2; only the edge columns remain to be masked.
      done_nxt = (state == STREAM) && (col_cnt >= COL_W'(2));
      if (col_last) begin
        col_nxt = '0;
        if (row_last) begin
          row_nxt        = '0;
          state_nxt      = FILL;
          frame_done_nxt = 1'b1;
        end else begin
          row_nxt = row_cnt + 1'b1;
          if (row_cnt == ROW_W'(1)) state_nxt = STREAM;
        end
      end else begin
        col_nxt = col_cnt + 1'b1;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      col_cnt      <= '0;
      row_cnt      <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      col_cnt      <= col_nxt;
      row_cnt      <= row_nxt;
      done_o       <= done_nxt;
      frame_done_o <= frame_done_nxt;
    end
  end

endmodule

// File: rtl/window_3x3_former.sv
// Sliding 3x3 window assembled from three vertically aligned pixel taps per beat.
// Datapath is inline; position tracking and validity flags live in the controller.
module window_3x3_former
  import window_3x3_former_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int IMG_WIDTH  = IMG_WIDTH_DFLT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  window_3x3_former_if.slave  bus
);

  logic [DATA_W-1:0]   win [3][3];
  logic [DATA_W-1:0]   taps [3];
  logic [9*DATA_W-1:0] win_flat;
  logic                done;
  logic                frame_done;

  assign taps[0] = bus.row0_i;
  assign taps[1] = bus.row1_i;
  assign taps[2] = bus.row2_i;

  // NOTE: the window registers are reset deliberately: a mid-frame reset must present
  // an all-zero window on the next cycle, so these cannot be left as plain storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      end
    end else if (bus.done_i) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= taps[r];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        win_flat[DATA_W*idx(r, c) +: DATA_W] = win[r][c];
      end
    end
  end

  window_3x3_controller #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .done_i       (bus.done_i),
    .done_o       (done),
    .frame_done_o (frame_done)
  );

  assign bus.window_o     = win_flat;
  assign bus.done_o       = done;
  assign bus.frame_done_o = frame_done;

endmodule
